// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the external memory bus controller: FSM states,
// access sizes, the I/O address region and the beat-count helper.
package mem_ctrl_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_IC_RD  = 2'd1;
    localparam logic [1:0] ST_LSB_RD = 2'd2;
    localparam logic [1:0] ST_LSB_WR = 2'd3;

    // Access sizes as presented by the load/store buffer
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Address bits [17:16] equal to this value select I/O space
    localparam logic [1:0]  IO_REGION  = 2'b11;
    localparam logic [31:0] IO_TX_ADDR = 32'h0003_0000;

    // Number of byte beats needed for an access size (3 behaves as word)
    function automatic logic [2:0] beats_for_size(input logic [1:0] size);
        case (size)
            SZ_B:    beats_for_size = 3'd1;
            SZ_H:    beats_for_size = 3'd2;
            default: beats_for_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory bus controller: arbitrates instruction-cache and load/store
// requests onto the 8-bit external bus, one byte beat per cycle, and
// reassembles little-endian read data. I/O-space writes are throttled by
// the UART buffer-full flag and a minimum gap between I/O write beats.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int IO_WRITE_GAP = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_ready,
    output logic [31:0]           ic_data,
    input  logic                  lsb_req,
    input  logic                  lsb_we,
    input  logic [1:0]            lsb_size,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_wdata,
    output logic                  lsb_ready,
    output logic [31:0]           lsb_rdata,
    input  logic                  clear_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    logic [1:0]            state_reg;
    logic [2:0]            cnt_reg;        // beats issued so far
    logic [2:0]            nbeat_reg;      // beats required by this access
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [31:0]           wdata_reg;
    logic [31:0]           buf_reg;        // read bytes assembled so far
    logic                  cap_pending_reg; // previous cycle issued a read beat
    logic [1:0]            cap_idx_reg;    // byte lane of that beat
    logic [15:0]           gap_reg;        // cycles left before next I/O write
    logic                  ic_ready_reg;
    logic [31:0]           ic_data_reg;
    logic                  lsb_ready_reg;
    logic                  lsb_ready_rd_reg; // pending lsb ready belongs to a load
    logic [31:0]           lsb_rdata_reg;

    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  beat_is_io;
    logic                  issue_rd;
    logic                  issue_wr;
    logic [31:0]           buf_next;
    logic                  last_cap;
    logic                  take_lsb;
    logic                  take_ic;

    // Beat issue, byte capture merge and request acceptance
    always_comb begin
        beat_addr  = base_reg + ADDR_WIDTH'(cnt_reg);
        beat_is_io = (beat_addr[17:16] == IO_REGION);
        issue_rd   = ((state_reg == ST_IC_RD) || (state_reg == ST_LSB_RD))
                     && rdy_in && (cnt_reg < nbeat_reg);
        issue_wr   = (state_reg == ST_LSB_WR) && rdy_in && (cnt_reg < nbeat_reg)
                     && (!beat_is_io || (!io_buffer_full && (gap_reg == 16'd0)));
        buf_next = buf_reg;
        if (cap_pending_reg) begin
            buf_next[8*cap_idx_reg +: 8] = mem_din;
        end
        last_cap = cap_pending_reg && ((3'(cap_idx_reg) + 3'd1) == nbeat_reg);
        // A requester whose ready pulse is on the wire this cycle is ignored
        take_lsb = (state_reg == ST_IDLE) && rdy_in && !clear_in
                   && lsb_req && !lsb_ready_reg;
        take_ic  = (state_reg == ST_IDLE) && rdy_in && !clear_in
                   && ic_req && !ic_ready_reg && !take_lsb;
    end

    // Bus drive: zeros whenever no beat is being issued
    always_comb begin
        mem_wr   = issue_wr;
        mem_a    = (issue_rd || issue_wr) ? beat_addr : '0;
        mem_dout = issue_wr ? wdata_reg[8*cnt_reg[1:0] +: 8] : 8'h00;
    end

    // A flush cancels a read ready pulse that is already registered
    always_comb begin
        ic_ready  = ic_ready_reg && !clear_in;
        lsb_ready = lsb_ready_reg && !(clear_in && lsb_ready_rd_reg);
        ic_data   = ic_data_reg;
        lsb_rdata = lsb_rdata_reg;
    end

    // Transaction sequencing, read capture and I/O write pacing
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            nbeat_reg        <= '0;
            base_reg         <= '0;
            wdata_reg        <= '0;
            buf_reg          <= '0;
            cap_pending_reg  <= 1'b0;
            cap_idx_reg      <= '0;
            gap_reg          <= '0;
            ic_ready_reg     <= 1'b0;
            ic_data_reg      <= '0;
            lsb_ready_reg    <= 1'b0;
            lsb_ready_rd_reg <= 1'b0;
            lsb_rdata_reg    <= '0;
        end else begin
            ic_ready_reg     <= 1'b0;
            lsb_ready_reg    <= 1'b0;
            lsb_ready_rd_reg <= 1'b0;
            cap_pending_reg  <= issue_rd;
            cap_idx_reg      <= cnt_reg[1:0];
            if (cap_pending_reg) begin
                buf_reg <= buf_next;
            end
            if (issue_wr && beat_is_io) begin
                gap_reg <= 16'(IO_WRITE_GAP);
            end else if (rdy_in && (gap_reg != 16'd0)) begin
                gap_reg <= gap_reg - 16'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (take_lsb) begin
                        base_reg  <= lsb_addr;
                        wdata_reg <= lsb_wdata;
                        nbeat_reg <= beats_for_size(lsb_size);
                        cnt_reg   <= '0;
                        buf_reg   <= '0;
                        state_reg <= lsb_we ? ST_LSB_WR : ST_LSB_RD;
                    end else if (take_ic) begin
                        base_reg  <= ic_addr;
                        nbeat_reg <= 3'd4;
                        cnt_reg   <= '0;
                        buf_reg   <= '0;
                        state_reg <= ST_IC_RD;
                    end
                end
                ST_IC_RD, ST_LSB_RD: begin
                    if (clear_in) begin
                        state_reg       <= ST_IDLE;
                        cap_pending_reg <= 1'b0;
                    end else begin
                        if (issue_rd) begin
                            cnt_reg <= cnt_reg + 3'd1;
                        end
                        if (last_cap) begin
                            state_reg <= ST_IDLE;
                            if (state_reg == ST_IC_RD) begin
                                ic_ready_reg <= 1'b1;
                                ic_data_reg  <= buf_next;
                            end else begin
                                lsb_ready_reg    <= 1'b1;
                                lsb_ready_rd_reg <= 1'b1;
                                lsb_rdata_reg    <= buf_next;
                            end
                        end
                    end
                end
                default: begin
                    if (issue_wr) begin
                        cnt_reg <= cnt_reg + 3'd1;
                        if ((cnt_reg + 3'd1) == nbeat_reg) begin
                            state_reg     <= ST_IDLE;
                            lsb_ready_reg <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
